// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - single-burst AXI read-channel arbiter for N masters sharing one slave
//
// Purpose: grants one master at a time the AR/R path to a shared read-only
// slave. The grant is held from AR arbitration until the RLAST beat completes.
// Round-robin by default. Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority,
// where the lowest index wins.
// The R beat count is checked against the granted ARLEN.
//
// Ports:
//   clk, arst                       clock, asynchronous active-high reset
//   m_arvalid_i/araddr_i/arid_i/arlen_i, m_arready_o   per-master AR channels (packed)
//   m_rvalid_o, m_rready_i          per-master R handshake
//   m_rdata_o/rresp_o/rlast_o/rid_o R payload broadcast to all masters
//   s_ar*_o, s_arready_i            slave AR channel
//   s_r*_i, s_rready_o              slave R channel
//   grant_o                         one-hot current owner, 0 when idle
//   proto_err_o                     sticky RLAST/beat-count mismatch
module axi_rd_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [N_MASTERS-1:0]           m_arvalid_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr_i,
  input  logic [N_MASTERS*ID_WIDTH-1:0]  m_arid_i,
  input  logic [N_MASTERS*8-1:0]         m_arlen_i,
  output logic [N_MASTERS-1:0]           m_arready_o,
  output logic [N_MASTERS-1:0]           m_rvalid_o,
  output logic [DATA_WIDTH-1:0]          m_rdata_o,
  output logic [1:0]                     m_rresp_o,
  output logic                           m_rlast_o,
  output logic [ID_WIDTH-1:0]            m_rid_o,
  input  logic [N_MASTERS-1:0]           m_rready_i,
  output logic                           s_arvalid_o,
  output logic [ADDR_WIDTH-1:0]          s_araddr_o,
  output logic [ID_WIDTH-1:0]            s_arid_o,
  output logic [7:0]                     s_arlen_o,
  input  logic                           s_arready_i,
  input  logic                           s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          s_rdata_i,
  input  logic [1:0]                     s_rresp_i,
  input  logic                           s_rlast_i,
  input  logic [ID_WIDTH-1:0]            s_rid_i,
  output logic                           s_rready_o,
  output logic [N_MASTERS-1:0]           grant_o,
  output logic                           proto_err_o
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state;
  logic [N_MASTERS-1:0] grant_q;
  logic [IW-1:0]        gidx;
  logic [7:0]           arlen_q;
  logic [8:0]           beat_cnt;
  logic                 proto_err_q;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic                 ar_hs;
  logic                 r_hs;

`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  logic [IW-1:0]        last_grant;
`endif

  // Requester selection, evaluated every cycle but only consumed in IDLE.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest requesting index is the last one written.
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (m_arvalid_i[IW'(k)]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(k);
      end
    end
`else
    for (int k = 0; k < N_MASTERS; k++) begin
      int cand;
      // Candidate index is last_grant+1+k, wrapped into 0..N_MASTERS-1.
      cand = int'(last_grant) + 1 + k;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      if (!pick_valid && m_arvalid_i[IW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
`endif
  end

  // AR channel: combinational pass-through from the granted master.
  assign s_arvalid_o = (state == ADDR) & m_arvalid_i[gidx];
  assign s_araddr_o  = m_araddr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_arid_o    = m_arid_i[int'(gidx)*ID_WIDTH +: ID_WIDTH];
  assign s_arlen_o   = m_arlen_i[int'(gidx)*8 +: 8];
  assign m_arready_o = (state == ADDR) ? (grant_q & {N_MASTERS{s_arready_i}}) : '0;
  assign ar_hs       = s_arvalid_o & s_arready_i;

  // R channel: handshake is steered to the owner only while in DATA.
  assign s_rready_o  = (state == DATA) & m_rready_i[gidx];
  assign m_rvalid_o  = (state == DATA) ? (grant_q & {N_MASTERS{s_rvalid_i}}) : '0;
  assign r_hs        = (state == DATA) & s_rvalid_i & s_rready_o;
  assign m_rdata_o   = s_rdata_i;
  assign m_rresp_o   = s_rresp_i;
  assign m_rlast_o   = s_rlast_i;
  assign m_rid_o     = s_rid_i;

  assign grant_o     = grant_q;
  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      grant_q     <= '0;
      gidx        <= '0;
      arlen_q     <= '0;
      beat_cnt    <= '0;
      proto_err_q <= 1'b0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      last_grant  <= IW'(N_MASTERS - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= {{(N_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
            gidx    <= pick_idx;
            arlen_q <= m_arlen_i[int'(pick_idx)*8 +: 8];
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (s_rlast_i) begin
              // beat_cnt holds the number of beats before this one.
              if (beat_cnt != {1'b0, arlen_q}) proto_err_q <= 1'b1;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
              last_grant <= gidx;
`endif
              grant_q <= '0;
              state   <= IDLE;
            end else if (beat_cnt == {1'b0, arlen_q}) begin
              // Overrun: flag it but keep the grant until RLAST arrives.
              proto_err_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    m_arvalid_i;
  logic [N*AW-1:0] m_araddr_i;
  logic [N*IW-1:0] m_arid_i;
  logic [N*8-1:0]  m_arlen_i;
  logic [N-1:0]    m_arready_o;
  logic [N-1:0]    m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic [1:0]      m_rresp_o;
  logic            m_rlast_o;
  logic [IW-1:0]   m_rid_o;
  logic [N-1:0]    m_rready_i;
  logic            s_arvalid_o;
  logic [AW-1:0]   s_araddr_o;
  logic [IW-1:0]   s_arid_o;
  logic [7:0]      s_arlen_o;
  logic            s_arready_i;
  logic            s_rvalid_i;
  logic [DW-1:0]   s_rdata_i;
  logic [1:0]      s_rresp_i;
  logic            s_rlast_i;
  logic [IW-1:0]   s_rid_i;
  logic            s_rready_o;
  logic [N-1:0]    grant_o;
  logic            proto_err_o;

  int n_checks = 0;
  int n_errors = 0;

  axi_rd_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .arst(arst),
    .m_arvalid_i(m_arvalid_i), .m_araddr_i(m_araddr_i), .m_arid_i(m_arid_i),
    .m_arlen_i(m_arlen_i), .m_arready_o(m_arready_o),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o),
    .m_rlast_o(m_rlast_o), .m_rid_o(m_rid_o), .m_rready_i(m_rready_i),
    .s_arvalid_o(s_arvalid_o), .s_araddr_o(s_araddr_o), .s_arid_o(s_arid_o),
    .s_arlen_o(s_arlen_o), .s_arready_i(s_arready_i),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i),
    .s_rlast_i(s_rlast_i), .s_rid_i(s_rid_i), .s_rready_o(s_rready_o),
    .grant_o(grant_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ar(input int m, input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    m_araddr_i[m*AW +: AW] = addr;
    m_arlen_i[m*8 +: 8]    = len;
    m_arid_i[m*IW +: IW]   = id;
    m_arvalid_i[m]         = 1'b1;
  endtask

  // Arbitration edge, AR handshake, then nbeats slave beats (RLAST on the last).
  // The caller has already raised arvalid for master m.
  task automatic do_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] id, input int nbeats, input bit toggle);
    logic rr;
    bit   accepted;
    int   tries;
    step();
    check("grant", grant_o, 64'(1 << m));
    check("s_arvalid", s_arvalid_o, 1);
    check("s_araddr", s_araddr_o, addr);
    check("s_arlen", s_arlen_o, len);
    check("s_arid", s_arid_o, id);
    check("arready_wait", m_arready_o, 0);
    s_arready_i = 1'b1;
    settle();
    check("arready", m_arready_o, 64'(1 << m));
    step();
    s_arready_i    = 1'b0;
    m_arvalid_i[m] = 1'b0;
    settle();
    check("s_arvalid_data", s_arvalid_o, 0);
    rr = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      s_rvalid_i = 1'b1;
      s_rdata_i  = addr + 32'(b);
      s_rid_i    = id;
      s_rlast_i  = (b == nbeats - 1);
      accepted   = 1'b0;
      tries      = 0;
      while (!accepted && tries < 4) begin
        m_rready_i = toggle ? (rr ? N'(1 << m) : '0) : '1;
        settle();
        check("m_rvalid", m_rvalid_o, 64'(1 << m));
        check("s_rready", s_rready_o, toggle ? rr : 1'b1);
        check("m_rdata", m_rdata_o, addr + 32'(b));
        accepted = toggle ? rr : 1'b1;
        if (toggle) rr = ~rr;
        step();
        tries++;
      end
      check("beat_accepted", accepted, 1);
    end
    s_rvalid_i = 1'b0;
    s_rlast_i  = 1'b0;
    m_rready_i = '1;
    settle();
    check("grant_idle", grant_o, 0);
    check("s_arvalid_idle", s_arvalid_o, 0);
  endtask

  initial begin
    arst = 1'b1;
    m_arvalid_i = '0; m_araddr_i = '0; m_arid_i = '0; m_arlen_i = '0;
    m_rready_i = '1;
    s_arready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0; s_rresp_i = 2'b00;
    s_rlast_i = 1'b0; s_rid_i = '0;
    step(); step();
    check("rst_grant", grant_o, 0);
    check("rst_proto", proto_err_o, 0);
    check("rst_s_arvalid", s_arvalid_o, 0);
    check("rst_arready", m_arready_o, 0);
    check("rst_s_rready", s_rready_o, 0);
    check("rst_rvalid", m_rvalid_o, 0);
    arst = 1'b0;
    step();

    // Simultaneous requests from reset: master 0 then master 1, twice.
    for (int r = 0; r < 2; r++) begin
      set_ar(0, 32'h1000_0000, 8'd0, 8'h10);
      set_ar(1, 32'h2000_0000, 8'd1, 8'h21);
      do_burst(0, 32'h1000_0000, 8'd0, 8'h10, 1, 1'b0);
      do_burst(1, 32'h2000_0000, 8'd1, 8'h21, 2, 1'b0);
    end
    check("proto_sim", proto_err_o, 0);

    // Single request, ARLEN=3, four beats.
    set_ar(0, 32'h8000_0000, 8'd3, 8'h05);
    do_burst(0, 32'h8000_0000, 8'd3, 8'h05, 4, 1'b0);
    check("proto_single", proto_err_o, 0);

    // Both requesting right after master 0 was served.
    set_ar(0, 32'h3000_0000, 8'd0, 8'h30);
    set_ar(1, 32'h4000_0000, 8'd0, 8'h40);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    do_burst(0, 32'h3000_0000, 8'd0, 8'h30, 1, 1'b0);
    do_burst(1, 32'h4000_0000, 8'd0, 8'h40, 1, 1'b0);
`else
    do_burst(1, 32'h4000_0000, 8'd0, 8'h40, 1, 1'b0);
    do_burst(0, 32'h3000_0000, 8'd0, 8'h30, 1, 1'b0);
`endif

    // Backpressure on master 1.
    set_ar(1, 32'h5000_0000, 8'd3, 8'h51);
    do_burst(1, 32'h5000_0000, 8'd3, 8'h51, 4, 1'b1);
    check("proto_bp", proto_err_o, 0);

    // Stray R beat while idle.
    s_rvalid_i = 1'b1;
    s_rlast_i  = 1'b1;
    m_rready_i = '1;
    settle();
    check("stray_s_rready", s_rready_o, 0);
    check("stray_rvalid", m_rvalid_o, 0);
    step();
    check("stray_grant", grant_o, 0);
    s_rvalid_i = 1'b0;
    s_rlast_i  = 1'b0;

    // Short burst: ARLEN=3 with RLAST on beat 2.
    set_ar(0, 32'h6000_0000, 8'd3, 8'h60);
    do_burst(0, 32'h6000_0000, 8'd3, 8'h60, 3, 1'b0);
    check("proto_short", proto_err_o, 1);
    step();
    check("proto_sticky", proto_err_o, 1);

    // Reset during beat 1 of a 4-beat burst.
    set_ar(0, 32'h7000_0000, 8'd3, 8'h70);
    step();
    check("rst_mid_grant0", grant_o, 1);
    s_arready_i = 1'b1;
    step();
    s_arready_i = 1'b0;
    m_arvalid_i[0] = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h7000_0000;
    step();
    s_rdata_i  = 32'h7000_0001;
    settle();
    check("rst_mid_rready_pre", s_rready_o, 1);
    arst = 1'b1;
    settle();
    check("rst_mid_grant", grant_o, 0);
    check("rst_mid_s_rready", s_rready_o, 0);
    check("rst_mid_rvalid", m_rvalid_o, 0);
    check("rst_mid_proto", proto_err_o, 0);
    s_rvalid_i = 1'b0;
    step();
    arst = 1'b0;
    set_ar(0, 32'h7100_0000, 8'd0, 8'h71);
    set_ar(1, 32'h7200_0000, 8'd0, 8'h72);
    do_burst(0, 32'h7100_0000, 8'd0, 8'h71, 1, 1'b0);
    do_burst(1, 32'h7200_0000, 8'd0, 8'h72, 1, 1'b0);
    check("proto_after_rst", proto_err_o, 0);

    // Overrun: ARLEN=1 but RLAST only on the third beat; grant held until then.
    set_ar(0, 32'h9000_0000, 8'd1, 8'h90);
    do_burst(0, 32'h9000_0000, 8'd1, 8'h90, 3, 1'b0);
    check("proto_overrun", proto_err_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
